// File: rtl/spi_slave_if.sv
// SPI slave front-end for the single-port sync RAM.
// Deserialises MSB-first MOSI frames {cmd[1:0], payload} into rx_data with a one-cycle
// rx_valid strobe, and serialises one RAM read byte MSB-first on MISO per READ_DATA frame.
module spi_slave_if #(
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int unsigned FW     = ADDR_SIZE + 2;
  localparam int unsigned CntW   = $clog2(FW + 1);
  localparam int unsigned TxCntW = $clog2(ADDR_SIZE + 1);

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;      // frame bits still to sample; 0 = done
  logic [FW-1:0]        shift_q, shift_d;
  logic [FW-1:0]        rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rd_addr_seen_q, rd_addr_seen_d;
  logic                 tx_armed_q, tx_armed_d;    // tx_valid trusted from now on
  logic                 tx_loaded_q, tx_loaded_d;  // byte already taken this frame
  logic                 tx_busy_q, tx_busy_d;      // byte being shifted out
  logic [ADDR_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [TxCntW-1:0]    tx_cnt_q, tx_cnt_d;        // bits left after the current one
  logic                 miso_q, miso_d;
  logic [FW-1:0]        frame_next;

  // Next-state, frame capture and MISO serialiser.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_armed_d     = tx_armed_q;
    tx_loaded_d    = tx_loaded_q;
    tx_busy_d      = tx_busy_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    miso_d         = 1'b0;
    frame_next     = {shift_q[FW-2:0], mosi};

    unique case (state_q)
      StIdle: begin
        if (!ss_n) begin
          state_d = StChkCmd;
        end
      end

      StChkCmd: begin
        if (ss_n) begin
          state_d = StIdle;
        end else begin
          shift_d   = {{(FW-1){1'b0}}, mosi};
          bit_cnt_d = CntW'(FW - 1);
          if (!mosi) begin
            state_d = StWrite;
          end else if (!rd_addr_seen_q) begin
            state_d = StReadAdd;
          end else begin
            state_d = StReadData;
          end
        end
      end

      StWrite, StReadAdd, StReadData: begin
        if (ss_n) begin
          // Abort: drop partial frame and any byte in flight; rd_addr_seen is kept.
          state_d     = StIdle;
          bit_cnt_d   = '0;
          tx_armed_d  = 1'b0;
          tx_loaded_d = 1'b0;
          tx_busy_d   = 1'b0;
          tx_cnt_d    = '0;
        end else begin
          if (bit_cnt_q != '0) begin
            shift_d   = frame_next;
            bit_cnt_d = bit_cnt_q - 1'b1;
            if (bit_cnt_q == CntW'(1)) begin
              rx_data_d  = frame_next;
              rx_valid_d = 1'b1;
              if (state_q == StReadAdd) begin
                rd_addr_seen_d = 1'b1;
              end
            end
          end

          if (state_q == StReadData) begin
            if (tx_busy_q) begin
              if (tx_cnt_q != '0) begin
                miso_d     = tx_shift_q[ADDR_SIZE-1];
                tx_shift_d = tx_shift_q << 1;
                tx_cnt_d   = tx_cnt_q - 1'b1;
              end else begin
                tx_busy_d      = 1'b0;
                rd_addr_seen_d = 1'b0;
              end
            end else if (tx_armed_q && !tx_loaded_q && tx_valid) begin
              miso_d      = tx_data[ADDR_SIZE-1];
              tx_shift_d  = tx_data << 1;
              tx_cnt_d    = TxCntW'(ADDR_SIZE - 1);
              tx_busy_d   = 1'b1;
              tx_loaded_d = 1'b1;
            end
            // The RAM consumes rx_valid on this edge; tx_valid may still be stale here.
            if (rx_valid_q) begin
              tx_armed_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_armed_q     <= 1'b0;
      tx_loaded_q    <= 1'b0;
      tx_busy_q      <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_armed_q     <= tx_armed_d;
      tx_loaded_q    <= tx_loaded_d;
      tx_busy_q      <= tx_busy_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      miso_q         <= miso_d;
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
